bit_slip_aligner: RTL and testbench

BIT_SLIP_ALIGNER -- requirements
Module: bit_slip_aligner

---
 rtl/bit_slip_aligner.sv | 161 ++++++++++++++++
 tb/tb_bit_slip_aligner.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_slip_aligner.sv
// bit_slip_aligner
//   Recovers word alignment of a serial-derived data stream. Each valid input
//   word is rotated left by slip_amt; in HUNT the slip advances on every
//   non-matching word until the frame sync pattern appears. CONFIRM then checks
//   that the pattern recurs every FRAME_LEN words, and LOCK tolerates isolated
//   sync misses before giving up.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din_valid   input word qualifier
//   din         raw, possibly misaligned word
//   dout_valid  output qualifier (one cycle after din_valid)
//   dout        aligned word, held while din_valid is low
//   slip_amt    current rotate-left amount applied to din
//   locked      high while the aligner is in LOCK
//   sof         dout is a sync word at the expected frame position
module bit_slip_aligner #(
  parameter int                 A_width     = 16,
  parameter int                 SH_width    = 4,
  parameter logic [A_width-1:0] SYNC_WORD   = A_width'(16'hF628),
  parameter int                 FRAME_LEN   = 8,
  parameter int                 CONFIRM_CNT = 3,
  parameter int                 LOSS_CNT    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din_valid,
  input  logic [A_width-1:0]  din,
  output logic                dout_valid,
  output logic [A_width-1:0]  dout,
  output logic [SH_width-1:0] slip_amt,
  output logic                locked,
  output logic                sof
);

  localparam int WC_W = $clog2(FRAME_LEN);
  localparam int HC_W = $clog2(CONFIRM_CNT + 1);
  localparam int MC_W = $clog2(LOSS_CNT + 1);

  localparam logic [WC_W-1:0]     WORD_LAST    = WC_W'(FRAME_LEN - 1);
  localparam logic [HC_W-1:0]     CONFIRM_LAST = HC_W'(CONFIRM_CNT - 1);
  localparam logic [MC_W-1:0]     LOSS_LAST    = MC_W'(LOSS_CNT - 1);
  localparam logic [SH_width-1:0] SLIP_LAST    = SH_width'(A_width - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCK    = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [SH_width-1:0] slip_nxt, slip_inc;
  logic [WC_W-1:0]     word_cnt, word_nxt, word_inc;
  logic [HC_W-1:0]     hit_cnt, hit_nxt;
  logic [MC_W-1:0]     miss_cnt, miss_nxt;
  logic [2*A_width-1:0] rot_dbl;
  logic [A_width-1:0]  rot;
  logic                is_sync;
  logic                at_pos;

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    slip_nxt  = slip_amt;
    word_nxt  = word_cnt;
    hit_nxt   = hit_cnt;
    miss_nxt  = miss_cnt;

    // Rotating the doubled word left leaves din rotated left in the upper half:
    // bits shifted past the MSB of the lower copy reappear at its LSB.
    rot_dbl = {din, din} << slip_amt;
    rot     = rot_dbl[2*A_width-1:A_width];

    is_sync  = (rot == SYNC_WORD);
    at_pos   = (state != HUNT) && (word_cnt == '0);
    word_inc = (word_cnt == WORD_LAST) ? '0 : word_cnt + WC_W'(1);
    slip_inc = (slip_amt == SLIP_LAST) ? '0 : slip_amt + SH_width'(1);

    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (is_sync) begin
            // The matching word is frame position 0; the next word is 1.
            state_nxt = (CONFIRM_CNT == 1) ? LOCK : CONFIRM;
            word_nxt  = WC_W'(1);
            hit_nxt   = HC_W'(1);
            miss_nxt  = '0;
          end else begin
            slip_nxt = slip_inc;
          end
        end
        CONFIRM: begin
          word_nxt = word_inc;
          if (at_pos) begin
            if (is_sync) begin
              hit_nxt = hit_cnt + HC_W'(1);
              if (hit_cnt == CONFIRM_LAST) begin
                state_nxt = LOCK;
                miss_nxt  = '0;
              end
            end else begin
              state_nxt = HUNT;
              slip_nxt  = slip_inc;
              word_nxt  = '0;
              hit_nxt   = '0;
              miss_nxt  = '0;
            end
          end
        end
        LOCK: begin
          word_nxt = word_inc;
          if (at_pos) begin
            if (is_sync) begin
              miss_nxt = '0;
            end else if (miss_cnt == LOSS_LAST) begin
              state_nxt = HUNT;
              slip_nxt  = slip_inc;
              word_nxt  = '0;
              hit_nxt   = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + MC_W'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slip_amt   <= '0;
      word_cnt   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_nxt;
      slip_amt   <= slip_nxt;
      word_cnt   <= word_nxt;
      hit_cnt    <= hit_nxt;
      miss_cnt   <= miss_nxt;
      dout_valid <= din_valid;
      sof        <= din_valid && at_pos && is_sync;
      if (din_valid) begin
        dout <= rot;
      end
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_bit_slip_aligner.sv
// tb_bit_slip_aligner
//   Self-checking bench for bit_slip_aligner: a directed vector table for the
//   initial hunt, hand sequences for framing, loss, wrap, gapped input and
//   asynchronous reset, a 12-bit build for the slip wrap, and a randomized
//   framed stream compared against a word-level reference model.
module tb_bit_slip_aligner;

  localparam int          W    = 16;
  localparam logic [15:0] SYNC = 16'hF628;
  localparam int          FL   = 8;
  localparam int          CC   = 3;
  localparam int          LC   = 2;
  localparam logic [15:0] SKEWED = 16'h47B1;  // SYNC rotated right by 5

  localparam int M_HUNT    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_LOCK    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] din = '0;
  logic        dout_valid;
  logic [15:0] dout;
  logic [3:0]  slip_amt;
  logic        locked;
  logic        sof;

  logic        din_valid12 = 1'b0;
  logic [11:0] din12 = '0;
  logic        dout_valid12;
  logic [11:0] dout12;
  logic [3:0]  slip_amt12;
  logic        locked12;
  logic        sof12;

  bit_slip_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout),
    .slip_amt   (slip_amt),
    .locked     (locked),
    .sof        (sof)
  );

  bit_slip_aligner #(
    .A_width   (12),
    .SH_width  (4),
    .SYNC_WORD (12'hA5C)
  ) dut12 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid12),
    .din        (din12),
    .dout_valid (dout_valid12),
    .dout       (dout12),
    .slip_amt   (slip_amt12),
    .locked     (locked12),
    .sof        (sof12)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word-level framing rules) -------------
  int          m_mode, m_slip, m_pos, m_hits, m_misses;
  logic [15:0] e_dout;
  logic        e_valid, e_sof;

  function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
    logic [31:0] v;
    v = {16'h0000, x};
    return 16'(((v << s) | (v >> (16 - s))) & 32'h0000FFFF);
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] x, input int s);
    return rotl(x, (16 - s) % 16);
  endfunction

  task automatic model_reset();
    m_mode = M_HUNT; m_slip = 0; m_pos = 0; m_hits = 0; m_misses = 0;
    e_dout = '0; e_valid = 1'b0; e_sof = 1'b0;
  endtask

  task automatic model_restart();
    m_mode = M_HUNT; m_slip = (m_slip + 1) % W; m_pos = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d);
    logic [15:0] r;
    logic        expected_pos;
    e_valid = v;
    e_sof   = 1'b0;
    if (!v) return;
    r = rotl(d, m_slip);
    e_dout = r;
    expected_pos = (m_mode != M_HUNT) && ((m_pos % FL) == 0);
    e_sof = expected_pos && (r == SYNC);
    if (m_mode == M_HUNT) begin
      if (r == SYNC) begin
        m_mode = (CC == 1) ? M_LOCK : M_CONFIRM;
        m_pos = 1; m_hits = 1; m_misses = 0;
      end else begin
        m_slip = (m_slip + 1) % W;
      end
    end else begin
      m_pos++;
      if (expected_pos) begin
        if (m_mode == M_CONFIRM) begin
          if (r == SYNC) begin
            m_hits++;
            if (m_hits == CC) m_mode = M_LOCK;
          end else begin
            model_restart();
          end
        end else begin
          if (r == SYNC) m_misses = 0;
          else begin
            m_misses++;
            if (m_misses == LC) model_restart();
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_valid));
    check({tag, ".dout"},       32'(dout),       32'(e_dout));
    check({tag, ".sof"},        32'(sof),        32'(e_sof));
    check({tag, ".locked"},     32'(locked),     32'(m_mode == M_LOCK));
    check({tag, ".slip_amt"},   32'(slip_amt),   32'(m_slip));
  endtask

  // Present one input cycle, then sample 1 time unit after the edge.
  task automatic apply(input string tag, input logic v, input logic [15:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    model_step(v, d);
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    din_valid12 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dv;
    logic        sof;
    logic        locked;
    logic [3:0]  slip;
  } vec_t;

  vec_t vecs[7];

  int g_k, g_pos, sof_count;
  logic [15:0] w;
  logic        gv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    // hunt from slip 0 on a stream skewed by 5; one idle cycle holds dout
    vecs[0] = '{1'b1, SKEWED, 16'h47B1, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[1] = '{1'b1, SKEWED, 16'h8F62, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[2] = '{1'b1, SKEWED, 16'h1EC5, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[3] = '{1'b1, SKEWED, 16'h3D8A, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[4] = '{1'b1, SKEWED, 16'h7B14, 1'b1, 1'b0, 1'b0, 4'd5};
    vecs[5] = '{1'b0, 16'h1234, 16'h7B14, 1'b0, 1'b0, 1'b0, 4'd5};
    vecs[6] = '{1'b1, SKEWED, 16'hF628, 1'b1, 1'b0, 1'b0, 4'd5};

    // ---- reset state ----
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset.dout", 32'(dout), 32'h0);
    check("reset.dout_valid", 32'(dout_valid), 32'h0);
    check("reset.sof", 32'(sof), 32'h0);
    check("reset.locked", 32'(locked), 32'h0);
    check("reset.slip_amt", 32'(slip_amt), 32'h0);
    do_reset();

    // ---- table: hunt steps 0..5, hit on 6th valid word ----
    for (int i = 0; i < 7; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].v, vecs[i].din);
      check($sformatf("vec%0d.dout", i),   32'(dout),       32'(vecs[i].dout));
      check($sformatf("vec%0d.dv", i),     32'(dout_valid), 32'(vecs[i].dv));
      check($sformatf("vec%0d.sof", i),    32'(sof),        32'(vecs[i].sof));
      check($sformatf("vec%0d.locked", i), 32'(locked),     32'(vecs[i].locked));
      check($sformatf("vec%0d.slip", i),   32'(slip_amt),   32'(vecs[i].slip));
    end

    // ---- confirm: two more frames lock, one sof per frame ----
    for (int f = 0; f < 3; f++) begin
      sof_count = 0;
      for (int j = 1; j < FL; j++) begin
        apply("frame_data", 1'b1, 16'h1234 + 16'(j));
        sof_count += int'(sof);
      end
      apply("frame_sync", 1'b1, SKEWED);
      sof_count += int'(sof);
      check($sformatf("frame%0d.sof", f), 32'(sof), 32'h1);
      check($sformatf("frame%0d.locked", f), 32'(locked), (f >= 1) ? 32'h1 : 32'h0);
      check($sformatf("frame%0d.sof_count", f), 32'(sof_count), 32'h1);
    end

    // ---- loss tolerance: single miss kept, double miss drops ----
    for (int f = 0; f < 4; f++) begin
      for (int j = 1; j < FL; j++) apply("loss_data", 1'b1, 16'h5555 + 16'(j));
      apply("loss_sync", 1'b1, (f == 1) ? SKEWED : 16'h47B0);
      if (f < 3) begin
        check($sformatf("loss%0d.locked", f), 32'(locked), 32'h1);
        check($sformatf("loss%0d.slip", f), 32'(slip_amt), 32'd5);
      end else begin
        check("loss_drop.locked", 32'(locked), 32'h0);
        check("loss_drop.slip", 32'(slip_amt), 32'd6);
      end
    end

    // ---- slip wrap 15 -> 0 on a miss ----
    for (int j = 0; j < 9; j++) apply("wrap_miss", 1'b1, 16'h0000);
    check("wrap.slip15", 32'(slip_amt), 32'd15);
    apply("wrap_miss", 1'b1, 16'h0000);
    check("wrap.slip0", 32'(slip_amt), 32'd0);

    // ---- gapped input during confirm ----
    do_reset();
    for (int j = 0; j < 6; j++) apply("gap_hunt", 1'b1, SKEWED);
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j < FL; j++) begin
        apply("gap_data", 1'b1, 16'h0F0F + 16'(j));
        apply("gap_idle", 1'b0, SKEWED);
      end
      if (f == 1) check("gap.locked_before", 32'(locked), 32'h0);
      apply("gap_sync", 1'b1, SKEWED);
      check($sformatf("gap%0d.sof", f), 32'(sof), 32'h1);
      apply("gap_idle", 1'b0, SKEWED);
    end
    check("gap.locked_after", 32'(locked), 32'h1);

    // ---- asynchronous reset mid-frame in LOCK ----
    for (int j = 1; j < 4; j++) apply("async_data", 1'b1, 16'hAAAA + 16'(j));
    check("async.pre_locked", 32'(locked), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.dout", 32'(dout), 32'h0);
    check("async.dout_valid", 32'(dout_valid), 32'h0);
    check("async.sof", 32'(sof), 32'h0);
    check("async.locked", 32'(locked), 32'h0);
    check("async.slip_amt", 32'(slip_amt), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply("async_resume", 1'b1, SKEWED);
    check("async_resume.dout", 32'(dout), 32'h47B1);
    check("async_resume.slip", 32'(slip_amt), 32'd1);

    // ---- 12-bit build: slip wraps 11 -> 0, then a hit at slip 0 ----
    din_valid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      din_valid12 = 1'b1;
      din12 = 12'h000;
      @(posedge clk);
      #1;
      check($sformatf("w12.slip%0d", j), 32'(slip_amt12), 32'((j + 1) % 12));
    end
    din12 = 12'hA5C;
    @(posedge clk);
    #1;
    check("w12.hit_dout", 32'(dout12), 32'hA5C);
    check("w12.hit_slip", 32'(slip_amt12), 32'h0);
    din_valid12 = 1'b0;
    model_step(1'b0, 16'h0000);

    // ---- randomized framed stream against the model ----
    do_reset();
    g_k = 3;
    g_pos = 0;
    for (int c = 0; c < 3000; c++) begin
      gv = ($urandom_range(3) != 0);
      w  = 16'($urandom);
      if (gv) begin
        if (g_pos == 0) begin
          if ($urandom_range(40) == 0) g_k = $urandom_range(15);
          w = rotr(SYNC, g_k);
          if ($urandom_range(9) == 0) w = w ^ 16'h0100;
        end
        g_pos = (g_pos + 1) % FL;
      end
      apply("rand", gv, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
